// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : RV32I instruction fetch stage. Owns the PC, a word-addressed
//            instruction memory with a 1-cycle synchronous read, and a
//            2-entry output queue with a valid/ready handshake to decode.
//            Supports redirect with flush, decode back-pressure,
//            out-of-range fault tagging and a runtime program-load port.
// Macro    : FETCH_MISALIGN_TRAP_EN - when defined, a fetch from a PC with
//            pc[1:0] != 0 delivers a NOP tagged with fault_o=1.
// Ports    : clk           rising-edge clock
//            rst           asynchronous active-low reset
//            redirect_i    flush and restart at redirect_pc_i
//            redirect_pc_i byte address of the redirect target
//            ready_i       decode accepts the current output
//            valid_o       inst_o/pc_o/fault_o hold a valid instruction
//            inst_o        instruction word (0 when valid_o=0)
//            pc_o          byte address of inst_o (0 when valid_o=0)
//            fault_o       fetch fault for this entry (0 when valid_o=0)
//            prog_we_i     program-load write enable
//            prog_addr_i   program-load word address
//            prog_data_i   program-load data
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 256,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter                  INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_i,
    input  logic [XLEN-1:0]          redirect_pc_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [XLEN-1:0]          inst_o,
    output logic [XLEN-1:0]          pc_o,
    output logic                     fault_o,
    input  logic                     prog_we_i,
    input  logic [$clog2(DEPTH)-1:0] prog_addr_i,
    input  logic [XLEN-1:0]          prog_data_i
);

    localparam int              c_aw  = $clog2(DEPTH);
    localparam int              c_ew  = 2 * XLEN + 1;   // {fault, pc, inst}
    localparam logic [XLEN-1:0] c_nop = XLEN'(32'h0000_0013);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] pc_q,         pc_d;
    logic            inflight_q,   inflight_d;
    logic [XLEN-1:0] infl_pc_q,    infl_pc_d;
    logic            infl_fault_q, infl_fault_d;
    logic            started_q,    started_d;
    logic [1:0]      count_q,      count_d;
    logic [c_ew-1:0] q0_q,         q0_d;
    logic [c_ew-1:0] q1_q,         q1_d;
    logic [XLEN-1:0] rdata_q;

    logic [XLEN-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [c_aw-1:0] w_word_idx;
    logic            w_oor;
    logic            w_mis;
    logic            w_issue;
    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic [1:0]      w_cnt_mid;
    logic [c_ew-1:0] w_q0_mid;
    logic [c_ew-1:0] w_bypass;
    logic [c_ew-1:0] w_head;

    assign w_word_idx = pc_q[c_aw+1:2];

    generate
        if (XLEN > c_aw + 2) begin : g_oor
            assign w_oor = |pc_q[XLEN-1:c_aw+2];
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_mis = |pc_q[1:0];
`else
    assign w_mis = 1'b0;
`endif

    // The just-completed read is visible as a bypass entry behind the queued
    // ones, so a fetch reaches decode the cycle after it was issued.
    assign w_bypass = {infl_fault_q, infl_pc_q, (infl_fault_q ? c_nop : rdata_q)};

    always_comb begin
        w_valid      = (count_q != 2'd0) || inflight_q;
        w_head       = (count_q != 2'd0) ? q0_q : w_bypass;
        w_pop        = w_valid && ready_i;
        w_issue      = started_q && !redirect_i &&
                       (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2);

        // Pop of a queued entry shifts the queue down.
        w_cnt_mid    = count_q;
        w_q0_mid     = q0_q;
        if (w_pop && (count_q != 2'd0)) begin
            w_cnt_mid = count_q - 2'd1;
            w_q0_mid  = q1_q;
        end

        // The completing fetch enters the queue unless decode took it directly.
        w_push       = inflight_q && !(w_pop && (count_q == 2'd0));

        q0_d         = w_q0_mid;
        q1_d         = q1_q;
        count_d      = w_cnt_mid;
        if (w_push) begin
            if (w_cnt_mid == 2'd0) begin
                q0_d = w_bypass;
            end else begin
                q1_d = w_bypass;
            end
            count_d = w_cnt_mid + 2'd1;
        end

        inflight_d   = w_issue;
        pc_d         = w_issue ? (pc_q + XLEN'(4)) : pc_q;
        infl_pc_d    = w_issue ? pc_q : infl_pc_q;
        infl_fault_d = w_issue ? (w_oor || w_mis) : infl_fault_q;

        // Redirect flushes everything, including a same-cycle pop or push.
        if (redirect_i) begin
            count_d    = 2'd0;
            inflight_d = 1'b0;
            pc_d       = redirect_pc_i;
        end

        // The first cycle after reset release behaves like a redirect cycle
        // (no issue), so reset and redirect share the same restart latency.
        started_d    = 1'b1;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            inflight_q   <= 1'b0;
            infl_pc_q    <= '0;
            infl_fault_q <= 1'b0;
            started_q    <= 1'b0;
            count_q      <= 2'd0;
            q0_q         <= '0;
            q1_q         <= '0;
        end else begin
            pc_q         <= pc_d;
            inflight_q   <= inflight_d;
            infl_pc_q    <= infl_pc_d;
            infl_fault_q <= infl_fault_d;
            started_q    <= started_d;
            count_q      <= count_d;
            q0_q         <= q0_d;
            q1_q         <= q1_d;
        end
    end

    // Instruction memory: not reset. A same-cycle write and read of one word
    // returns the old contents because both use non-blocking updates.
    always_ff @(posedge clk) begin
        if (prog_we_i) begin
            mem[prog_addr_i] <= prog_data_i;
        end
        if (w_issue) begin
            rdata_q <= mem[w_word_idx];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign valid_o = w_valid;
    assign fault_o = w_valid ? w_head[c_ew-1]           : 1'b0;
    assign pc_o    = w_valid ? w_head[c_ew-2:XLEN]      : '0;
    assign inst_o  = w_valid ? w_head[XLEN-1:0]         : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A transaction-level model
//            predicts the delivered stream (PC sequence after each redirect,
//            memory image, fault rule) and when valid_o must be high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        fault_o;
    logic        prog_we_i;
    logic [7:0]  prog_addr_i;
    logic [31:0] prog_data_i;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN      (32),
        .DEPTH     (256),
        .RESET_PC  (32'h0000_0000),
        .INIT_FILE ("")
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ready_i       (ready_i),
        .valid_o       (valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .fault_o       (fault_o),
        .prog_we_i     (prog_we_i),
        .prog_addr_i   (prog_addr_i),
        .prog_data_i   (prog_data_i)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] mem_m [256];
    logic        mon_en = 1'b0;
    int          age    = 0;
    logic [31:0] exp_pc = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected {fault, inst} for a fetch from byte address pc.
    function automatic logic [32:0] model(input logic [31:0] pc);
        logic f;
        f = (pc >= 32'h0000_0400);
`ifdef FETCH_MISALIGN_TRAP_EN
        if (pc[1:0] != 2'b00) f = 1'b1;
`endif
        return f ? {1'b1, 32'h0000_0013} : {1'b0, mem_m[pc[9:2]]};
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(0, 4))
            0:       t = 32'($urandom_range(0, 255)) << 2;
            1:       t = 32'h0000_03F0 + 32'(4 * $urandom_range(0, 7));
            2:       t = $urandom & 32'hFFFF_FFFC;
            3:       t = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
            default: t = 32'($urandom_range(0, 1023));
        endcase
        return t;
    endfunction

    // Model: valid_o is high from the 2nd cycle after a restart onward, and
    // every accepted transfer is the next PC of the current stream.
    always @(negedge clk) begin : p_mon
        logic [32:0] e;
        if (mon_en) begin
            if (age < 100000) age = age + 1;
            check("valid", 64'(valid_o), 64'(age >= 2));
            if (!valid_o) begin
                check("idle_out", {inst_o, pc_o}, 64'd0);
                check("idle_fault", 64'(fault_o), 64'd0);
            end
            if (valid_o && ready_i) begin
                e = model(exp_pc);
                check("xfer_pc", 64'(pc_o), 64'(exp_pc));
                check("xfer_inst", 64'(inst_o), 64'(e[31:0]));
                check("xfer_fault", 64'(fault_o), 64'(e[32]));
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_i) begin
                exp_pc = redirect_pc_i;
                age    = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = a;
        step();
        redirect_i    = 1'b0;
        step();
        @(negedge clk);
    endtask

    logic [31:0] boot [4];
    logic [32:0] e8;

    initial begin
        boot[0] = 32'h0050_0093;
        boot[1] = 32'h00a0_0113;
        boot[2] = 32'h0020_81b3;
        boot[3] = 32'h0000_0013;
        rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b0;
        prog_we_i = 1'b0; prog_addr_i = '0; prog_data_i = '0;

        // Program load while held in reset.
        for (int i = 0; i < 256; i++) begin
            step();
            prog_we_i   = 1'b1;
            prog_addr_i = 8'(i);
            prog_data_i = (i < 4) ? boot[i] : ((i == 5) ? 32'h1111_1111 : $urandom);
            mem_m[i]    = prog_data_i;
        end
        step();
        prog_we_i = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_out", {inst_o, pc_o}, 64'd0);

        // Reset release and stream.
        step();
        rst = 1'b1; ready_i = 1'b1; age = -1; exp_pc = 32'h0; mon_en = 1'b1;
        @(negedge clk); check("boot_c0", 64'(valid_o), 64'd0);
        step(); @(negedge clk); check("boot_c1", 64'(valid_o), 64'd0);
        step(); @(negedge clk);
        check("boot_c2_valid", 64'(valid_o), 64'd1);
        check("boot_c2_pc", 64'(pc_o), 64'h0);
        check("boot_c2_inst", 64'(inst_o), 64'h0050_0093);
        step(); @(negedge clk);
        check("boot_c3_pc", 64'(pc_o), 64'h4);
        check("boot_c3_inst", 64'(inst_o), 64'h00a0_0113);

        // Back-pressure for 5 cycles with pc 8 at the head.
        step();
        ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_pc", 64'(pc_o), 64'h8);
            check("bp_inst", 64'(inst_o), 64'h0020_81b3);
            step();
        end
        ready_i = 1'b1;
        @(negedge clk); check("bp_resume_pc8", 64'(pc_o), 64'h8);
        step(); @(negedge clk); check("bp_resume_pc12", 64'(pc_o), 64'hC);

        // Redirect with a full queue.
        step(); ready_i = 1'b0;
        step(); step(); step();
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        step();
        redirect_i = 1'b0; ready_i = 1'b1;
        @(negedge clk); check("redir_n1_valid", 64'(valid_o), 64'd0);
        step(); @(negedge clk);
        check("redir_n2_valid", 64'(valid_o), 64'd1);
        check("redir_n2_pc", 64'(pc_o), 64'h40);
        check("redir_n2_inst", 64'(inst_o), 64'(mem_m[16]));

        // Memory range boundary.
        redirect_to(32'h400);
        check("oor_inst", 64'(inst_o), 64'h13);
        check("oor_fault", 64'(fault_o), 64'd1);
        check("oor_pc", 64'(pc_o), 64'h400);
        redirect_to(32'h3FC);
        check("last_fault", 64'(fault_o), 64'd0);
        check("last_inst", 64'(inst_o), 64'(mem_m[255]));

        // Program load (stream is out of range, no word-5 reads pending).
        step();
        prog_we_i = 1'b1; prog_addr_i = 8'd5; prog_data_i = 32'hDEAD_BEEF;
        mem_m[5] = 32'hDEAD_BEEF;
        step();
        prog_we_i = 1'b0;
        redirect_to(32'h14);
        check("load_inst", 64'(inst_o), 64'hDEAD_BEEF);

        // Write in the same cycle the target word is read.
        step(); redirect_i = 1'b1; redirect_pc_i = 32'h14;
        step(); redirect_i = 1'b0;
        prog_we_i = 1'b1; prog_addr_i = 8'd5; prog_data_i = 32'hCAFE_F00D;
        step(); prog_we_i = 1'b0;
        @(negedge clk);
        check("wr_same_cyc_inst", 64'(inst_o), 64'hDEAD_BEEF);
        check("wr_same_cyc_pc", 64'(pc_o), 64'h14);
        step(); mem_m[5] = 32'hCAFE_F00D;
        redirect_to(32'h14);
        check("wr_new_inst", 64'(inst_o), 64'hCAFE_F00D);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step();
            ready_i       = ($urandom_range(0, 9) < 7);
            redirect_i    = ($urandom_range(0, 19) == 0);
            redirect_pc_i = rand_target();
        end
        step(); redirect_i = 1'b0; ready_i = 1'b1;

        // Asynchronous reset with a full queue.
        step(); ready_i = 1'b0;
        step(); step(); step();
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", 64'(valid_o), 64'd0);
        check("async_rst_pc", 64'(pc_o), 64'd0);
        step(); step();
        rst = 1'b1; ready_i = 1'b1; age = -1; exp_pc = 32'h0; mon_en = 1'b1;
        @(negedge clk); step(); @(negedge clk); step(); @(negedge clk);
        check("rst_restart_valid", 64'(valid_o), 64'd1);
        check("rst_restart_pc", 64'(pc_o), 64'h0);

        // Misaligned redirect.
        redirect_to(32'h22);
        e8 = {1'b0, mem_m[8]};
`ifdef FETCH_MISALIGN_TRAP_EN
        e8 = {1'b1, 32'h0000_0013};
`endif
        check("mis_pc", 64'(pc_o), 64'h22);
        check("mis_inst", 64'(inst_o), 64'(e8[31:0]));
        check("mis_fault", 64'(fault_o), 64'(e8[32]));

        repeat (5) step();
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
